// File: rtl/rv_mc_pkg.sv
// rtl/rv_mc_pkg.sv - shared types and encodings for the multicycle RISC-V control path
//
// Purpose: phase/state encodings, base opcodes, opcode classes and PC source
//          selects shared by the phase sequencer and the opcode control decoder.
// Ports:   none (package).

package rv_mc_pkg;

  // Phase encodings double as the decoder's sel input, so the values are fixed.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // CLS_NONE is the post-reset value before any instruction has been decoded.
  typedef enum logic [3:0] {
    CLS_NONE   = 4'd0,
    CLS_R      = 4'd1,
    CLS_I      = 4'd2,
    CLS_LOAD   = 4'd3,
    CLS_STORE  = 4'd4,
    CLS_BRANCH = 4'd5,
    CLS_JAL    = 4'd6,
    CLS_JALR   = 4'd7,
    CLS_BAD    = 4'd8
  } op_class_t;

  localparam logic [1:0] PCSRC_PC4    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JAL    = 2'b10;
  localparam logic [1:0] PCSRC_JALR   = 2'b11;

endpackage

// File: rtl/rv_opcode_classify.sv
// rtl/rv_opcode_classify.sv - combinational opcode to instruction-class mapping
//
// Purpose: maps instruction[6:0] to an op_class; anything unrecognised is CLS_BAD.
// Ports:
//   opcode   in  7  instruction[6:0]
//   op_class out    decoded instruction class

module rv_opcode_classify
  import rv_mc_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  op_class
);

  always_comb begin
    op_class = CLS_BAD;
    case (opcode)
      OPC_R:      op_class = CLS_R;
      OPC_I:      op_class = CLS_I;
      OPC_LOAD:   op_class = CLS_LOAD;
      OPC_STORE:  op_class = CLS_STORE;
      OPC_BRANCH: op_class = CLS_BRANCH;
      OPC_JAL:    op_class = CLS_JAL;
      OPC_JALR:   op_class = CLS_JALR;
      default:    op_class = CLS_BAD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - phase sequencer for the multicycle RISC-V datapath
//
// Purpose: steps FETCH/DECODE/EXEC/MEM/WB, drives per-phase write enables and
//          the memory request, counts retired instructions, traps on bad opcodes.
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   opcode    in  7     instruction[6:0] from the IR, valid from DECODE
//   br_taken  in  1     branch compare result, used in EXEC
//   mem_ready in  1     memory completes the current request this cycle
//   phase     out 3     state register, feeds the control decoder's sel
//   mem_req, mem_is_data        memory request and address select
//   ir_write, pc_write, pc_src  IR / PC update controls
//   rf_write, dmem_read, dmem_write  register-file and data-memory strobes
//   illegal   out 1     sticky illegal-opcode flag
//   instret   out CNT_W retired-instruction count (wraps)

module multicycle_ctrl_fsm
  import rv_mc_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int PC_INIT_HOLD = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             br_taken,
  input  logic             mem_ready,
  output logic [2:0]       phase,
  output logic             mem_req,
  output logic             mem_is_data,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             rf_write,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  localparam int HOLD_W = (PC_INIT_HOLD > 1) ? $clog2(PC_INIT_HOLD + 1) : 1;

  state_t              r_state;
  op_class_t           r_class;
  logic [HOLD_W-1:0]   r_hold;
  logic                r_illegal;
  logic [CNT_W-1:0]    r_instret;

  op_class_t           w_class;
  logic                w_hold_done;
  logic                w_retire;

  rv_opcode_classify u_classify (
    .opcode   (opcode),
    .op_class (w_class)
  );

  assign w_hold_done = (r_hold == '0);

  // Retire on the edge that leaves the last state of an instruction.
  assign w_retire = ((r_state == ST_EXEC) && (r_class == CLS_BRANCH)) ||
                    ((r_state == ST_MEM) && (r_class == CLS_STORE) && mem_ready) ||
                    (r_state == ST_WB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_FETCH;
      r_class   <= CLS_NONE;
      r_hold    <= HOLD_W'(PC_INIT_HOLD);
      r_illegal <= 1'b0;
      r_instret <= '0;
    end else begin
      if (w_retire) begin
        r_instret <= r_instret + CNT_W'(1);
      end
      case (r_state)
        ST_FETCH: begin
          if (!w_hold_done) begin
            r_hold <= r_hold - HOLD_W'(1);
          end else if (mem_ready) begin
            r_state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          r_class <= w_class;
          if (w_class == CLS_BAD) begin
            r_state   <= ST_TRAP;
            r_illegal <= 1'b1;
          end else begin
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (r_class)
            CLS_BRANCH:                      r_state <= ST_FETCH;
            CLS_LOAD, CLS_STORE:             r_state <= ST_MEM;
            CLS_R, CLS_I, CLS_JAL, CLS_JALR: r_state <= ST_WB;
            default: begin
              // Unreachable: BAD never leaves DECODE except to TRAP.
              r_state   <= ST_TRAP;
              r_illegal <= 1'b1;
            end
          endcase
        end
        ST_MEM: begin
          if (mem_ready) begin
            r_state <= (r_class == CLS_STORE) ? ST_FETCH : ST_WB;
          end
        end
        ST_WB:   r_state <= ST_FETCH;
        ST_TRAP: r_state <= ST_TRAP;
        default: begin
          r_state   <= ST_TRAP;
          r_illegal <= 1'b1;
        end
      endcase
    end
  end

  // Strobes are decoded from the state and gated by rst_n so that an abort
  // drops them immediately, without waiting for a clock edge.
  always_comb begin
    mem_req     = 1'b0;
    mem_is_data = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = PCSRC_PC4;
    rf_write    = 1'b0;
    dmem_read   = 1'b0;
    dmem_write  = 1'b0;
    if (rst_n) begin
      case (r_state)
        ST_FETCH: begin
          if (w_hold_done) begin
            mem_req  = 1'b1;
            ir_write = mem_ready;
            pc_write = mem_ready;
          end
        end
        ST_EXEC: begin
          case (r_class)
            CLS_BRANCH: begin
              pc_write = br_taken;
              pc_src   = PCSRC_BRANCH;
            end
            CLS_JAL: begin
              pc_write = 1'b1;
              pc_src   = PCSRC_JAL;
            end
            CLS_JALR: begin
              pc_write = 1'b1;
              pc_src   = PCSRC_JALR;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          mem_req     = 1'b1;
          mem_is_data = 1'b1;
          dmem_read   = (r_class == CLS_LOAD);
          dmem_write  = (r_class == CLS_STORE);
        end
        ST_WB:   rf_write = 1'b1;
        default: ;
      endcase
    end
  end

  assign phase   = r_state;
  assign illegal = r_illegal;
  assign instret = r_instret;

endmodule
